mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage data-access controller. Consumes the EX/MEM pipeline-register outputs and issues
//  loads/stores on the req/ack data bus toward the AXI-Lite bridge.
//  Holds the pipeline via stall_req until the access completes, then presents the write-back result.
//  Non-memory ops pass straight through with zero added latency.
// PARAMETERS
//  ADDR_W  32  data-bus address width (data width fixed at `REG_DATA_BUS, 32 bits)
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   synchronous reset, active-high (`RST_ENABLE)
//  mem_alu_op          in   `ALU_OP_BUS  op from EX/MEM; memory ops are `EXE_{LB,LBU,LH,LHU,LW,SB,SH,SW}_OP
//  mem_mem_addr        in   32  effective address
//  mem_operand_2       in   32  store data (rt)
//  mem_reg_write_data  in   32  ALU result (non-load)
//  mem_reg_write_addr  in   5   destination register
//  mem_reg_write_en    in   1   destination write enable
//  stall               in   6   pipeline stall vector; only stall[4] is used
//  wb_reg_write_data   out  32  result to MEM/WB
//  wb_reg_write_addr   out  5   = mem_reg_write_addr
//  wb_reg_write_en     out  1   write enable to MEM/WB
//  stall_req           out  1   MEM stall request to the stall controller; stalls stages 0..4
//  addr_err_load       out  1   misaligned load
//  addr_err_store      out  1   misaligned store
//  data_req            out  1   bus request (registered)
//  data_wr             out  1   1 = store
//  data_size           out  2   0 = byte, 1 = half, 2 = word
//  data_addr           out  ADDR_W  byte address
//  data_wstrb          out  4   byte-lane strobes (stores only; 0 for loads)
//  data_wdata          out  32  lane-replicated store data
//  data_addr_ok        in   1   request accepted
//  data_data_ok        in   1   access complete; for loads, data_rdata is valid this cycle
//  data_rdata          in   32  load data, little-endian lanes
// BEHAVIOUR
//  Reset: state IDLE. data_req/wr/size/addr/wstrb/wdata = 0. Latched rdata = 0.
//    stall_req and addr_err_* = 0. wb_* = 0.
//  Misalignment (combinational):
//    - half ops fault when addr[0] != 0; word ops fault when addr[1:0] != 0.
//    - On a fault: addr_err_* = 1, wb_reg_write_en = 0, no bus request, no stall, FSM stays IDLE.
//  FSM IDLE -> REQ -> WAIT -> DONE -> IDLE:
//    - IDLE, aligned memory op: stall_req = 1 (combinational). Bus fields registered; data_req = 1
//      from next cycle; go to REQ.
//    - REQ: data_req, data_addr, data_size, data_wstrb, data_wdata held stable until data_addr_ok.
//      * On data_addr_ok: drop data_req next cycle; go to WAIT.
//      * If data_data_ok arrives in the same cycle: go directly to DONE.
//    - WAIT: on data_data_ok, latch data_rdata and go to DONE.
//    - stall_req = 1 throughout REQ and WAIT.
//    - DONE: stall_req = 0; wb_* driven from the latched data.
//      * stall[4] == `STOP (stalled by another source): remain in DONE, no re-issue.
//      * Otherwise: go to IDLE. The instruction advances on this edge and is never re-issued.
//  Store data and strobes:
//    - SB: wdata = {4{rt[7:0]}}, wstrb = 1 << addr[1:0].
//    - SH: wdata = {2{rt[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
//    - SW: wdata = rt, wstrb = 4'b1111.
//  Load results:
//    - LB/LBU: byte lane addr[1:0], sign/zero-extended.
//    - LH/LHU: half lane addr[1], sign/zero-extended.
//    - LW: full word.
//  wb_reg_write_data: non-load ops pass mem_reg_write_data through in any state; stores keep
//    mem_reg_write_en as supplied.
//  Reset mid-access: returns to IDLE and drops data_req immediately; the bridge discards the
//    outstanding response.
//  Stray data_addr_ok/data_data_ok in IDLE or DONE: ignored.
// TESTING
//  LW addr 0x100, addr_ok +2 cycles, data_ok +3 cycles, rdata 0xDEADBEEF
//    -> stall_req high 6 cycles; wb data 0xDEADBEEF, en 1, for one cycle.
//  LB addr 0x103, rdata 0x80FFFFFF -> wb 0xFFFFFF80. LBU -> 0x00000080.
//  SH addr 0x202, rt 0x1234ABCD -> wdata 0xABCDABCD, wstrb 1100, size 1, wr 1.
//  LW addr 0x101 -> addr_err_load 1, no data_req, stall_req 0, wb_reg_write_en 0.
//  addr_ok and data_ok in the same cycle with stall[4] = STOP for 2 cycles -> DONE held 3 cycles,
//    exactly one data_req.
//  rst asserted in WAIT -> next cycle IDLE, data_req 0, stall_req 0; a later LW completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: req/ack data bus between the MEM-stage controller and the AXI-Lite bridge
interface mem_access_ctrl_if #(parameter int ADDR_W = 32) ();
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );
    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller issuing req/ack bus accesses and holding the pipeline
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           mem_alu_op,
    input  logic [31:0]          mem_mem_addr,
    input  logic [31:0]          mem_operand_2,
    input  logic [31:0]          mem_reg_write_data,
    input  logic [4:0]           mem_reg_write_addr,
    input  logic                 mem_reg_write_en,
    input  logic [5:0]           stall,
    output logic [31:0]          wb_reg_write_data,
    output logic [4:0]           wb_reg_write_addr,
    output logic                 wb_reg_write_en,
    output logic                 stall_req,
    output logic                 addr_err_load,
    output logic                 addr_err_store,
    mem_access_ctrl_if.master    bus
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic       STOP       = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
    state_e            state_q, state_d;
    logic              req_q, req_d, wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d, st_wstrb;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d, st_wdata;
    logic [31:0]       b_sh, h_sh, ld_res;
    logic              is_byte, is_half, is_word, is_load, is_store, misalign, issue, done;
    logic              unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    always_comb begin
        is_byte  = mem_alu_op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
        is_half  = mem_alu_op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
        is_word  = mem_alu_op inside {EXE_LW_OP, EXE_SW_OP};
        is_load  = mem_alu_op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
        is_store = mem_alu_op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
        misalign = (is_half & mem_mem_addr[0]) | (is_word & |mem_mem_addr[1:0]);
        issue    = !rst & (state_q == S_IDLE) & (is_load | is_store) & !misalign;
        done     = state_q == S_DONE;
        st_wdata = is_byte ? {4{mem_operand_2[7:0]}} : is_half ? {2{mem_operand_2[15:0]}} : mem_operand_2;
        st_wstrb = is_byte ? 4'b0001 << mem_mem_addr[1:0] : is_half ? (mem_mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end

    // Load lanes are picked from the address captured at issue, against the latched response word.
    always_comb begin
        b_sh   = rdata_q >> {addr_q[1:0], 3'b000};
        h_sh   = rdata_q >> {addr_q[1], 4'b0000};
        ld_res = mem_alu_op == EXE_LB_OP  ? {{24{b_sh[7]}}, b_sh[7:0]} :
                 mem_alu_op == EXE_LBU_OP ? {24'b0, b_sh[7:0]} :
                 mem_alu_op == EXE_LH_OP  ? {{16{h_sh[15]}}, h_sh[15:0]} :
                 mem_alu_op == EXE_LHU_OP ? {16'b0, h_sh[15:0]} : rdata_q;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (issue) begin
                state_d = S_REQ;
                req_d   = 1'b1;
                wr_d    = is_store;
                size_d  = is_byte ? 2'd0 : is_half ? 2'd1 : 2'd2;
                addr_d  = mem_mem_addr[ADDR_W-1:0];
                wstrb_d = is_store ? st_wstrb : 4'b0000;
                wdata_d = is_store ? st_wdata : 32'b0;
            end
            S_REQ: if (bus.data_addr_ok) begin
                req_d   = 1'b0;
                state_d = bus.data_data_ok ? S_DONE : S_WAIT;
                rdata_d = bus.data_data_ok ? bus.data_rdata : rdata_q;
            end
            S_WAIT: if (bus.data_data_ok) begin
                state_d = S_DONE;
                rdata_d = bus.data_rdata;
            end
            default: state_d = stall[4] == STOP ? S_DONE : S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wstrb_q <= 4'b0;
            wdata_q <= 32'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.data_req       = req_q;
    assign bus.data_wr        = wr_q;
    assign bus.data_size      = size_q;
    assign bus.data_addr      = addr_q;
    assign bus.data_wstrb     = wstrb_q;
    assign bus.data_wdata     = wdata_q;
    assign stall_req          = issue | (state_q == S_REQ) | (state_q == S_WAIT);
    assign addr_err_load      = !rst & is_load & misalign;
    assign addr_err_store     = !rst & is_store & misalign;
    assign wb_reg_write_addr  = rst ? 5'd0 : mem_reg_write_addr;
    assign wb_reg_write_en    = !rst & mem_reg_write_en & !misalign & (!is_load | done);
    assign wb_reg_write_data  = rst ? 32'b0 : (is_load & done) ? ld_res : mem_reg_write_data;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scoreboard bench; driver queues expected write-back/bus beats, monitor compares
module tb_mem_access_ctrl;
    localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4, LHU = 8'hE5;
    localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB, ADD = 8'h20, NOP = 8'h00;

    typedef struct packed {logic [31:0] d; logic en; logic [4:0] a; logic el; logic es;} wb_t;
    typedef struct packed {logic wr; logic [1:0] size; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata;} bus_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  mem_alu_op = NOP;
    logic [31:0] mem_mem_addr = '0, mem_operand_2 = '0, mem_reg_write_data = '0;
    logic [4:0]  mem_reg_write_addr = '0;
    logic        mem_reg_write_en = 1'b0;
    logic [5:0]  stall = '0;
    logic [31:0] wb_reg_write_data;
    logic [4:0]  wb_reg_write_addr;
    logic        wb_reg_write_en, stall_req, addr_err_load, addr_err_store;

    mem_access_ctrl_if #(.ADDR_W(32)) bus ();

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_alu_op(mem_alu_op), .mem_mem_addr(mem_mem_addr), .mem_operand_2(mem_operand_2),
        .mem_reg_write_data(mem_reg_write_data), .mem_reg_write_addr(mem_reg_write_addr),
        .mem_reg_write_en(mem_reg_write_en), .stall(stall),
        .wb_reg_write_data(wb_reg_write_data), .wb_reg_write_addr(wb_reg_write_addr),
        .wb_reg_write_en(wb_reg_write_en), .stall_req(stall_req),
        .addr_err_load(addr_err_load), .addr_err_store(addr_err_store), .bus(bus)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0, req_cnt = 0;
    logic live = 1'b0, req_prev = 1'b0;
    wb_t  wb_q[$];
    bus_t bus_q[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // Monitor: pops one expected write-back per unstalled cycle of a live instruction, one bus beat per accept.
    always @(negedge clk) begin
        if (live && !stall_req) begin
            if (wb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL wb_unexpected got %0h", wb_reg_write_data);
            end else
                chk("wb", {wb_reg_write_data, wb_reg_write_en, wb_reg_write_addr, addr_err_load, addr_err_store}, wb_q.pop_front());
        end
        if (bus.data_req && bus.data_addr_ok) begin
            if (bus_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL bus_unexpected got %0h", bus.data_addr);
            end else
                chk("bus", {bus.data_wr, bus.data_size, bus.data_addr, bus.data_wstrb, bus.data_wdata}, bus_q.pop_front());
        end
        if (bus.data_req && !req_prev) req_cnt++;
        req_prev = bus.data_req;
    end

    // ao/dd: cycles from issue to addr_ok, and from addr_ok to data_ok (-1 = no response).
    task automatic do_op(input logic [7:0] op, input logic [31:0] addr, rt, alu, input logic [4:0] waddr,
                         input logic wen, input int ao, dd, input logic [31:0] rd, input int stop,
                         input wb_t ew, input logic bv, input bus_t eb, input int exp_stall, exp_reqs);
        int cyc = 0, sc = 0, dc = 0, r0 = req_cnt;
        if (bv) bus_q.push_back(eb);
        for (int i = 0; i <= stop; i++) wb_q.push_back(ew);
        mem_alu_op = op; mem_mem_addr = addr; mem_operand_2 = rt;
        mem_reg_write_data = alu; mem_reg_write_addr = waddr; mem_reg_write_en = wen;
        live = 1'b1;
        while (1) begin
            stall = {1'b0, dc < stop, 4'b0000};
            bus.data_addr_ok = ao >= 0 && cyc == ao;
            bus.data_data_ok = ao >= 0 && cyc == ao + dd;
            bus.data_rdata = (ao >= 0 && cyc == ao + dd) ? rd : 32'h0BAD_F00D;
            @(negedge clk);
            if (stall_req) sc++; else dc++;
            if (dc > stop || cyc > 60) break;
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        live = 1'b0; stall = '0; mem_alu_op = NOP;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        if (cyc > 60) begin
            checks++; errors++;
            $display("FAIL timeout op %0h cycles %0d", op, cyc);
        end
        chk("stall_cycles", sc, exp_stall);
        chk("req_count", req_cnt - r0, exp_reqs);
    endtask

    initial begin
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
        mem_alu_op = LW; mem_mem_addr = 32'h100; mem_reg_write_data = 32'h5555_AAAA;
        mem_reg_write_addr = 5'd3; mem_reg_write_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall_req", stall_req, 0);
        chk("rst_data_req", bus.data_req, 0);
        chk("rst_bus", {bus.data_wr, bus.data_size, bus.data_addr, bus.data_wstrb, bus.data_wdata}, 0);
        chk("rst_wb", {wb_reg_write_data, wb_reg_write_en, wb_reg_write_addr, addr_err_load, addr_err_store}, 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_alu_op = NOP;
        // Reset while waiting for data: FSM abandons the access.
        bus_q.push_back(bus_t'{1'b0, 2'd2, 32'h300, 4'b0000, 32'h0});
        @(posedge clk); #1;
        mem_alu_op = LW; mem_mem_addr = 32'h300;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0;
        @(negedge clk);
        chk("wait_stall_req", stall_req, 1);
        @(posedge clk); #1;
        rst = 1'b1; mem_alu_op = NOP;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_data_req", bus.data_req, 0);
        chk("mid_rst_stall_req", stall_req, 0);
        @(posedge clk); #1;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("stray_data_ok_stall", stall_req, 0);
        @(posedge clk); #1;
        bus.data_data_ok = 1'b0;

        do_op(LW,  32'h100, 32'h0, 32'h1111_1111, 5'd5, 1'b1, 2, 3, 32'hDEAD_BEEF, 0,
              wb_t'{32'hDEAD_BEEF, 1'b1, 5'd5, 1'b0, 1'b0}, 1'b1, bus_t'{1'b0, 2'd2, 32'h100, 4'b0000, 32'h0}, 6, 1);
        do_op(LB,  32'h103, 32'h0, 32'h0, 5'd6, 1'b1, 1, 1, 32'h80FF_FFFF, 0,
              wb_t'{32'hFFFF_FF80, 1'b1, 5'd6, 1'b0, 1'b0}, 1'b1, bus_t'{1'b0, 2'd0, 32'h103, 4'b0000, 32'h0}, 3, 1);
        do_op(LBU, 32'h103, 32'h0, 32'h0, 5'd6, 1'b1, 1, 1, 32'h80FF_FFFF, 0,
              wb_t'{32'h0000_0080, 1'b1, 5'd6, 1'b0, 1'b0}, 1'b1, bus_t'{1'b0, 2'd0, 32'h103, 4'b0000, 32'h0}, 3, 1);
        do_op(SH,  32'h202, 32'h1234_ABCD, 32'h202, 5'd0, 1'b0, 1, 0, 32'h0, 0,
              wb_t'{32'h0000_0202, 1'b0, 5'd0, 1'b0, 1'b0}, 1'b1, bus_t'{1'b1, 2'd1, 32'h202, 4'b1100, 32'hABCD_ABCD}, 2, 1);
        do_op(LW,  32'h101, 32'h0, 32'h0, 5'd4, 1'b1, -1, 0, 32'h0, 0,
              wb_t'{32'h0, 1'b0, 5'd4, 1'b1, 1'b0}, 1'b0, bus_t'(0), 0, 0);
        do_op(LW,  32'h104, 32'h0, 32'h0, 5'd7, 1'b1, 1, 0, 32'hCAFE_F00D, 2,
              wb_t'{32'hCAFE_F00D, 1'b1, 5'd7, 1'b0, 1'b0}, 1'b1, bus_t'{1'b0, 2'd2, 32'h104, 4'b0000, 32'h0}, 2, 1);
        do_op(SB,  32'h201, 32'h0000_0055, 32'h99, 5'd0, 1'b0, 1, 2, 32'h0, 0,
              wb_t'{32'h0000_0099, 1'b0, 5'd0, 1'b0, 1'b0}, 1'b1, bus_t'{1'b1, 2'd0, 32'h201, 4'b0010, 32'h5555_5555}, 4, 1);
        do_op(SW,  32'h204, 32'h89AB_CDEF, 32'h204, 5'd0, 1'b0, 3, 0, 32'h0, 0,
              wb_t'{32'h0000_0204, 1'b0, 5'd0, 1'b0, 1'b0}, 1'b1, bus_t'{1'b1, 2'd2, 32'h204, 4'b1111, 32'h89AB_CDEF}, 4, 1);
        do_op(LH,  32'h102, 32'h0, 32'h0, 5'd8, 1'b1, 1, 0, 32'h8001_1234, 0,
              wb_t'{32'hFFFF_8001, 1'b1, 5'd8, 1'b0, 1'b0}, 1'b1, bus_t'{1'b0, 2'd1, 32'h102, 4'b0000, 32'h0}, 2, 1);
        do_op(LHU, 32'h102, 32'h0, 32'h0, 5'd8, 1'b1, 1, 0, 32'h8001_1234, 0,
              wb_t'{32'h0000_8001, 1'b1, 5'd8, 1'b0, 1'b0}, 1'b1, bus_t'{1'b0, 2'd1, 32'h102, 4'b0000, 32'h0}, 2, 1);
        do_op(SH,  32'h203, 32'h1234_ABCD, 32'h0, 5'd2, 1'b1, -1, 0, 32'h0, 0,
              wb_t'{32'h0, 1'b0, 5'd2, 1'b0, 1'b1}, 1'b0, bus_t'(0), 0, 0);
        do_op(ADD, 32'h0, 32'h0, 32'h1234_5678, 5'd9, 1'b1, -1, 0, 32'h0, 0,
              wb_t'{32'h1234_5678, 1'b1, 5'd9, 1'b0, 1'b0}, 1'b0, bus_t'(0), 0, 0);

        repeat (2) @(posedge clk);
        chk("wb_q_left", wb_q.size(), 0);
        chk("bus_q_left", bus_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
